// File: rtl/argmax_display.sv
// argmax_display: output stage of the MNIST classifier datapath.
// Accepts one frame of NUM_CLASSES signed scores over a valid/ready stream,
// registers the index of the largest score and drives HEX0 / LEDR from it.
// Optional build macro: ARGMAX_MARGIN_EN adds second-best tracking and
// reports best minus second-best on `margin`; otherwise `margin` is tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_INIT   | first cycle after reset release, not yet accepting scores
// S_IDLE   | waiting for the first score of a frame
// S_ACCUM  | comparing subsequent scores against the running best
// S_DONE   | one-cycle bubble while the result is presented
module argmax_display #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] score_data,
  input  logic              score_valid,
  input  logic              score_last,
  output logic              score_ready,
  output logic [3:0]        class_idx,
  output logic              class_valid,
  output logic              frame_err,
  output logic [7:0]        hex_out,
  output logic [9:0]        ledr_out,
  output logic [DATA_W-1:0] margin
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(NUM_CLASSES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic [3:0]        class_idx_q, class_idx_d;
  logic              class_valid_q, class_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        hex_out_q, hex_out_d;
  logic [9:0]        ledr_out_q, ledr_out_d;

  logic       beat;
  logic       new_best;
  logic [3:0] cnt_inc;
  logic       done_good;
  logic       done_err;

  function automatic logic [7:0] hex_enc(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  assign score_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign beat        = score_valid && score_ready;
  assign new_best    = $signed(score_data) > $signed(best_val_q);
  assign cnt_inc     = cnt_q + 4'd1;

  // Frame sequencing, running argmax and result capture on DONE entry.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_valid_d = 1'b0;
    frame_err_d   = frame_err_q;
    hex_out_d     = hex_out_q;
    ledr_out_d    = ledr_out_q;
    done_good     = 1'b0;
    done_err      = 1'b0;

    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (beat) begin
          best_val_d = score_data;
          best_idx_d = 4'd0;
          cnt_d      = 4'd1;
          if (score_last) begin
            // A one-beat frame is always short.
            state_d  = S_DONE;
            done_err = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (beat) begin
          // Strict compare: ties keep the lower index.
          if (new_best) begin
            best_val_d = score_data;
            best_idx_d = cnt_q;
          end
          cnt_d = cnt_inc;
          if (score_last) begin
            state_d = S_DONE;
            if (cnt_inc == LAST_CNT) done_good = 1'b1;
            else                     done_err  = 1'b1;
          end else if (cnt_inc == LAST_CNT) begin
            // Missing last: close the frame here so the next beat starts fresh.
            state_d  = S_DONE;
            done_err = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done_good) begin
      class_idx_d   = best_idx_d;
      class_valid_d = 1'b1;
      frame_err_d   = 1'b0;
      hex_out_d     = hex_enc(best_idx_d);
      ledr_out_d    = 10'd1 << best_idx_d;
    end
    if (done_err) begin
      frame_err_d = 1'b1;
      hex_out_d   = 8'h86;
    end
  end

  // State and result registers; reset blanks the display immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_INIT;
      cnt_q         <= 4'd0;
      best_val_q    <= '0;
      best_idx_q    <= 4'd0;
      class_idx_q   <= 4'd0;
      class_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      hex_out_q     <= 8'hFF;
      ledr_out_q    <= 10'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
      frame_err_q   <= frame_err_d;
      hex_out_q     <= hex_out_d;
      ledr_out_q    <= ledr_out_d;
    end
  end

  assign class_idx   = class_idx_q;
  assign class_valid = class_valid_q;
  assign frame_err   = frame_err_q;
  assign hex_out     = hex_out_q;
  assign ledr_out    = ledr_out_q;

`ifdef ARGMAX_MARGIN_EN
  localparam logic [DATA_W-1:0] VAL_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] VAL_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] second_val_q, second_val_d;
  logic [DATA_W-1:0] margin_q, margin_d;
  logic [DATA_W:0]   diff;

  // Second-best tracking and saturated margin capture on a good frame.
  always_comb begin
    second_val_d = second_val_q;
    margin_d     = margin_q;
    diff         = '0;

    if (beat && (state_q == S_IDLE)) begin
      second_val_d = VAL_MIN;
    end else if (beat && (state_q == S_ACCUM)) begin
      if (new_best)
        second_val_d = best_val_q;
      else if ($signed(score_data) > $signed(second_val_q))
        second_val_d = score_data;
    end

    if (done_good) begin
      // best >= second, so the widened difference is never negative.
      diff = {best_val_d[DATA_W-1], best_val_d} - {second_val_d[DATA_W-1], second_val_d};
      if (!diff[DATA_W] && diff[DATA_W-1]) margin_d = VAL_MAX;
      else                                 margin_d = diff[DATA_W-1:0];
    end
  end

  // Margin registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      second_val_q <= '0;
      margin_q     <= '0;
    end else begin
      second_val_q <= second_val_d;
      margin_q     <= margin_d;
    end
  end

  assign margin = margin_q;
`else
  assign margin = '0;
`endif

endmodule

// File: tb/tb_argmax_display.sv
// Self-checking bench for argmax_display: frames are driven beat by beat,
// the expected result of each frame is queued once its final beat is sent,
// and a monitor pops and compares when the DUT enters its DONE bubble.
module tb_argmax_display;

  localparam int NUM = 10;
`ifdef ARGMAX_MARGIN_EN
  localparam bit MARGIN_EN = 1'b1;
`else
  localparam bit MARGIN_EN = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic [15:0] score_data;
  logic        score_valid;
  logic        score_last;
  logic        score_ready;
  logic [3:0]  class_idx;
  logic        class_valid;
  logic        frame_err;
  logic [7:0]  hex_out;
  logic [9:0]  ledr_out;
  logic [15:0] margin;

  argmax_display #(.DATA_W(16), .NUM_CLASSES(NUM)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .score_data  (score_data),
    .score_valid (score_valid),
    .score_last  (score_last),
    .score_ready (score_ready),
    .class_idx   (class_idx),
    .class_valid (class_valid),
    .frame_err   (frame_err),
    .hex_out     (hex_out),
    .ledr_out    (ledr_out),
    .margin      (margin)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    bit         good;
    logic [3:0] idx;
    logic [9:0] ledr;
    logic [15:0] marg;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  int fr[NUM];
  logic [3:0]  model_idx    = 4'd0;
  logic [9:0]  model_ledr   = 10'd0;
  logic [15:0] model_margin = 16'd0;

  logic [7:0] hex_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic drive_beat(input logic [15:0] d, input logic l);
    int guard;
    guard       = 0;
    score_data  = d;
    score_last  = l;
    score_valid = 1'b1;
    while (!score_ready && guard < 50) begin
      @(posedge Clk); #1;
      guard++;
    end
    if (!score_ready) check("ready_timeout", {31'd0, score_ready}, 32'd1);
    @(posedge Clk); #1;
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  // Send fr[0..n-1]; optional 3-cycle valid gap after beat index gap_after.
  task automatic send_frame(input int n, input bit with_last, input int gap_after);
    exp_t e;
    int bi;
    int sec;
    int m;
    for (int i = 0; i < n; i++) begin
      drive_beat(16'(fr[i]), with_last && (i == n - 1));
      if (i == gap_after && i != n - 1) begin
        repeat (3) @(posedge Clk);
        #1;
      end
    end
    bi  = 0;
    sec = -1000000;
    for (int i = 1; i < n; i++) if (fr[i] > fr[bi]) bi = i;
    for (int i = 0; i < n; i++) if (i != bi && fr[i] > sec) sec = fr[i];
    e.good = with_last && (n == NUM);
    if (e.good) begin
      m = fr[bi] - sec;
      if (m > 32767) m = 32767;
      model_idx    = 4'(bi);
      model_ledr   = 10'd1 << bi;
      model_margin = 16'(m);
    end
    e.idx  = model_idx;
    e.ledr = model_ledr;
    e.marg = model_margin;
    exp_q.push_back(e);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NUM; i++) fr[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM; i++) fr[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hex"},   {24'd0, hex_out}, 32'hFF);
    check({tag, "_ledr"},  {22'd0, ledr_out}, 32'd0);
    check({tag, "_idx"},   {28'd0, class_idx}, 32'd0);
    check({tag, "_cv"},    {31'd0, class_valid}, 32'd0);
    check({tag, "_err"},   {31'd0, frame_err}, 32'd0);
    check({tag, "_marg"},  {16'd0, margin}, 32'd0);
    check({tag, "_ready"}, {31'd0, score_ready}, 32'd0);
  endtask

  // Monitor: a falling score_ready marks the DONE cycle where results appear.
  logic prev_ready = 1'b0;
  logic cv_prev    = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        prev_ready = 1'b0;
        cv_prev    = 1'b0;
      end else begin
        if (cv_prev) check("cv_width", {31'd0, class_valid}, 32'd0);
        cv_prev = 1'b0;
        if (prev_ready && !score_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("class_idx", {28'd0, class_idx}, {28'd0, e.idx});
            check("ledr_out", {22'd0, ledr_out}, {22'd0, e.ledr});
            check("margin", {16'd0, margin}, MARGIN_EN ? {16'd0, e.marg} : 32'd0);
            if (e.good) begin
              check("class_valid", {31'd0, class_valid}, 32'd1);
              check("frame_err", {31'd0, frame_err}, 32'd0);
              check("hex_out", {24'd0, hex_out}, {24'd0, hex_tab[e.idx]});
              cv_prev = 1'b1;
            end else begin
              check("class_valid_err", {31'd0, class_valid}, 32'd0);
              check("frame_err_set", {31'd0, frame_err}, 32'd1);
              check("hex_out_err", {24'd0, hex_out}, 32'h86);
            end
          end
        end
        prev_ready = score_ready;
      end
    end
  end

  initial begin
    Reset_n     = 1'b0;
    score_valid = 1'b0;
    score_last  = 1'b0;
    score_data  = 16'd0;

    repeat (5) @(posedge Clk);
    #1;
    check_reset_values("rst");
    Reset_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, score_ready}, 32'd0);
    @(posedge Clk); #1;
    check("ready_after_edge", {31'd0, score_ready}, 32'd1);

    // Reference frame: max 100 at index 2, runner-up 99.
    fr = '{-5, 3, 100, 7, 0, -1, 99, 2, 4, 1};
    send_frame(NUM, 1'b1, -1);

    // Extreme negatives, max at last index, valid gap after beat 4.
    fill_const(-32768);
    fr[9] = -32767;
    send_frame(NUM, 1'b1, 3);

    // Tie between index 3 and 7 keeps the lower index.
    fill_const(0);
    fr[3] = 500;
    fr[7] = 500;
    send_frame(NUM, 1'b1, -1);

    // Early last on beat 6.
    fill_random();
    send_frame(6, 1'b1, -1);

    // Good frame clears frame_err; max at 8.
    fill_const(-10);
    fr[8] = 20;
    send_frame(NUM, 1'b1, -1);

    // Missing last: ten beats then error, next frame starts fresh.
    fill_random();
    send_frame(NUM, 1'b0, -1);

    // Saturated margin: 32767 against -32768 everywhere else.
    fill_const(-32768);
    fr[4] = 32767;
    send_frame(NUM, 1'b1, -1);

    // Single-beat frame with last is short.
    fr[0] = 1234;
    send_frame(1, 1'b1, -1);

    for (int k = 0; k < 4; k++) begin
      fill_random();
      send_frame(NUM, 1'b1, (k == 1) ? 5 : -1);
    end

    // Establish a non-zero held result before the mid-frame reset.
    fill_const(1);
    fr[5] = 77;
    send_frame(NUM, 1'b1, -1);
    @(posedge Clk); #1;

    // Partial frame, then asynchronous reset.
    fr = '{10, 20, 5000, 30, 40, 0, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) drive_beat(16'(fr[i]), 1'b0);
    Reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_idx    = 4'd0;
    model_ledr   = 10'd0;
    model_margin = 16'd0;
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Full frame with max at index 0.
    fr = '{300, 299, -3, 100, 0, 5, 6, 7, 8, 9};
    send_frame(NUM, 1'b1, -1);

    repeat (4) @(posedge Clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/argmax_display.md
# argmax_display

Output stage of the MNIST classifier datapath. It sits directly downstream of the output-layer neuron array inside `top_level` and receives one frame of `NUM_CLASSES` signed scores, serially, over a valid/ready stream. It finds the index of the largest score and registers it as the predicted digit. The result drives one seven-segment digit (HEX0) and a one-hot LED bank (LEDR), and is held until the next frame completes.

## Interface
- `DATA_W`, 16, width of each signed two's-complement score
- `NUM_CLASSES`, 10, scores per frame; legal range 2..10
- `Clk` input 1: system clock (50 MHz)
- `Reset_n` input 1: asynchronous, active-low reset
- `score_data` input DATA_W: signed score for the current class
- `score_valid` input 1: upstream has a score on `score_data`
- `score_last` input 1: marks the final score of a frame
- `score_ready` output 1: block can accept a score
- `class_idx` output 4: predicted class, held between frames
- `class_valid` output 1: one-cycle pulse when a new `class_idx` is registered
- `frame_err` output 1: sticky flag; last frame had the wrong length
- `hex_out` output 8: active-low seven-segment pattern; bit7 is DP
- `ledr_out` output 10: one-hot of `class_idx`
- `margin` output DATA_W: best score minus second-best score (see Configuration)

## Operation
- A beat is accepted on a rising edge of `Clk` where `score_valid` and `score_ready` are both high.
- Internal beat counter `cnt` is 4 bits; running best `best_val` (signed DATA_W) and `best_idx` (4 bits).
- States:
  - IDLE: `score_ready`=1. The first accepted beat loads `best_val`=`score_data`, `best_idx`=0, `cnt`=1, then goes to ACCUM. If that beat also has `score_last` set, go to DONE with error.
  - ACCUM: `score_ready`=1. Each beat does a signed compare. If `score_data` > `best_val` (strict), load `best_val`/`best_idx`=`cnt`. Then `cnt` increments.
  - DONE: `score_ready`=0 for exactly one cycle, then return to IDLE.
- Ties keep the lower index, because the compare is strict.
- Frame length check. A frame is correct when `score_last` arrives on beat number `NUM_CLASSES`; then go to DONE.
  - `score_last` arrives early: go to DONE with error.
  - Beat `NUM_CLASSES` arrives without `score_last`: go to DONE with error.
  - Beats after DONE belong to the next frame. A missing `last` therefore resynchronises at the next frame boundary.
- Effects of DONE entry:
  - Good frame: register `class_idx`=`best_idx`, pulse `class_valid`, clear `frame_err`. Update `hex_out`/`ledr_out` in the same cycle.
  - Error frame: `class_idx` and `ledr_out` hold their previous values. No `class_valid` pulse. Set `frame_err`=1 and `hex_out`=8'h86 ("E").
- HEX encoding for digits 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. DP is always off (bit7=1).

## Timing
- Reset values: `score_ready`=0 while `Reset_n`=0, 1 from the first edge after release (IDLE). `class_idx`=0, `class_valid`=0, `frame_err`=0, `hex_out`=8'hFF (blank), `ledr_out`=0, `margin`=0.
- Latency: results are visible one edge after the final beat is accepted. `class_valid` is high for exactly that one cycle.
- Frame throughput: NUM_CLASSES+1 cycles minimum (one bubble cycle in DONE).
- Upstream must hold `score_data`/`score_last` stable while `score_valid`=1 and `score_ready`=0.
- `score_valid` gaps mid-frame are legal. State and counters hold.
- Reset asserted mid-frame discards the partial frame. All outputs return to their reset values immediately (asynchronously).

## Configuration
- `ARGMAX_MARGIN_EN` defined:
  - Also track a second-best value. A new best pushes the old best into second place; otherwise a beat greater than second replaces second.
  - On a good DONE, register `margin` = best − second, saturated to the DATA_W signed maximum. `margin` holds until the next good frame.
- `ARGMAX_MARGIN_EN` undefined: no second-best logic is built, and `margin` is constant 0.

## Test plan
- Reset held 5 cycles, then released. Required: `hex_out`=FF, `ledr_out`=0, `score_ready`=1 one cycle after release.
- Frame of scores {−5, 3, 100, 7, 0, −1, 99, 2, 4, 1}, `last` on beat 10. Required: `class_idx`=2, `hex_out`=A4, `ledr_out`=10'b0000000100, a single `class_valid` pulse one cycle after beat 10, and `margin`=1 when `ARGMAX_MARGIN_EN` is defined.
- All scores −32768 except index 9 = −32767, with `score_valid` dropped for 3 cycles after beat 4. Required: `class_idx`=9, `hex_out`=90.
- Tie: index 3 and index 7 both equal 500, all others 0. Required: `class_idx`=3.
- `score_last` on beat 6. Required: `frame_err`=1, `hex_out`=86, `ledr_out` keeps the prior value, no `class_valid`. A following good frame clears `frame_err`.
- Reset pulsed after beat 5 of a frame, then a full frame with the max at index 0. Required: `class_idx`=0, `hex_out`=C0, and no contamination from the partial frame.
